mem_access_arbiter: RTL

Sequences and shares the single external flash memory interface among three requesters in the FPGA main control path: camera image write (capture stream), SPI image read-out, and image erase. It grants ownership to exactly one requester at a time and drives the memory-side mux select. It enforces a per-grant timeout so a hung owner cannot lock the memory, and reports timeouts to the error table.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_timeout_ctr.sv | 43 ++++
 rtl/mem_access_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external flash arbiter.
//   - Requester indices into the req/done/grant vectors.
//   - Memory mux select encodings driven on mem_sel.
//   - Arbiter FSM state encodings.
package mem_arb_pkg;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned REQ_CAM   = 0;
   localparam int unsigned REQ_READ  = 1;
   localparam int unsigned REQ_ERASE = 2;

   // Select codes match the requester indices; SEL_NONE parks the mux.
   typedef enum logic [1:0] {
      SEL_CAM   = 2'd0,
      SEL_READ  = 2'd1,
      SEL_ERASE = 2'd2,
      SEL_NONE  = 2'd3
   } mem_sel_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StGap    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_timeout_ctr.sv
// Per-grant hold-time counter for the flash arbiter.
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   clr_i      force the count back to zero (has priority over en_i)
//   en_i       count one cycle
//   expired_o  high while enabled and the count sits at TIMEOUT_CYCLES-1
module mem_arb_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
   parameter int unsigned TO_W           = 24
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TO_W-1:0] LastCount = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The owner is released on expiry, so the count never needs to wrap.
   assign expired_o = en_i && (count_q == LastCount);

endmodule

// File: rtl/mem_access_arbiter.sv
// Grants the single external flash interface to one of three requesters
// (cam write, image read, erase), drives the memory mux select and revokes
// a grant whose owner holds it for TIMEOUT_CYCLES without pulsing done.
// Ports:
//   sysClk       system clock, rising edge
//   rst          synchronous active-high reset
//   req[2:0]     level requests: [0] cam write, [1] img read, [2] erase
//   done[2:0]    one-cycle pulse from the current owner ending its access
//   grant[2:0]   one-hot ownership, or zero
//   mem_sel[1:0] mux select: 0 cam, 1 read, 2 erase, 3 none
//   arb_busy     high while any grant is held
//   timeout_err  one-cycle pulse when a grant is revoked by timeout
//   timeout_id   index of the last timed-out owner, held until the next one
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
   parameter int unsigned TO_W           = 24
) (
   input  logic       sysClk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [2:0] done,
   output logic [2:0] grant,
   output logic [1:0] mem_sel,
   output logic       arb_busy,
   output logic       timeout_err,
   output logic [1:0] timeout_id
);

   arb_state_e state_q, state_d;
   logic [2:0] grant_q, grant_d;
   mem_sel_e   mem_sel_q, mem_sel_d;
   logic       rr_q, rr_d;
   logic       to_err_q, to_err_d;
   logic [1:0] to_id_q, to_id_d;

   logic       active;
   logic       owner_done;
   logic       expired;

   // Arbitration result for an IDLE/GAP cycle.
   logic [2:0] win_grant;
   mem_sel_e   win_sel;
   logic       win_rr;

   assign active     = (state_q == StActive);
   // Only the owner's done bit counts; grant_q masks everyone else.
   assign owner_done = |(done & grant_q);

   mem_arb_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TO_W          (TO_W)
   ) u_timeout_ctr (
      .clk_i    (sysClk),
      .rst_i    (rst),
      .clr_i    (!active),
      .en_i     (active),
      .expired_o(expired)
   );

   // Cam write has absolute priority; read and erase share via rr.
   always_comb begin
      win_grant = '0;
      win_sel   = SEL_NONE;
      win_rr    = rr_q;
      if (req[REQ_CAM]) begin
         win_grant[REQ_CAM] = 1'b1;
         win_sel            = SEL_CAM;
      end else if (req[REQ_READ] && (!req[REQ_ERASE] || !rr_q)) begin
         win_grant[REQ_READ] = 1'b1;
         win_sel             = SEL_READ;
         win_rr              = 1'b1;
      end else if (req[REQ_ERASE]) begin
         win_grant[REQ_ERASE] = 1'b1;
         win_sel              = SEL_ERASE;
         win_rr               = 1'b0;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge sysClk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         mem_sel_q <= SEL_NONE;
         rr_q      <= 1'b0;
         to_err_q  <= 1'b0;
         to_id_q   <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         mem_sel_q <= mem_sel_d;
         rr_q      <= rr_d;
         to_err_q  <= to_err_d;
         to_id_q   <= to_id_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StGap: state_d = (|req) ? StActive : StIdle;
         StActive:      state_d = (owner_done || expired) ? StGap : StActive;
         default:       state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      grant_d   = grant_q;
      mem_sel_d = mem_sel_q;
      rr_d      = rr_q;
      to_err_d  = 1'b0;
      to_id_d   = to_id_q;
      unique case (state_q)
         StIdle, StGap: begin
            grant_d   = win_grant;
            mem_sel_d = win_sel;
            rr_d      = win_rr;
         end
         StActive: begin
            // done beats a same-cycle expiry and suppresses the error pulse.
            if (owner_done) begin
               grant_d   = '0;
               mem_sel_d = SEL_NONE;
            end else if (expired) begin
               grant_d   = '0;
               mem_sel_d = SEL_NONE;
               to_err_d  = 1'b1;
               // Select codes equal requester indices.
               to_id_d   = mem_sel_q;
            end
         end
         default: begin
            grant_d   = '0;
            mem_sel_d = SEL_NONE;
         end
      endcase
   end

   assign grant       = grant_q;
   assign mem_sel     = mem_sel_q;
   assign arb_busy    = |grant_q;
   assign timeout_err = to_err_q;
   assign timeout_id  = to_id_q;

endmodule
